regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Multi-port register file for the decode stage: NUM_RD async read ports, NUM_WR write ports.
//  Adds same-cycle write->read bypass, optional hardwired-zero R0, per-register pending scoreboard
//  for hazard detection, and a sequential bulk-clear engine used on pipeline flush.
// PARAMETERS
//  DATA_W    16  register width in bits
//  ADDR_W    3   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD    2   read ports
//  NUM_WR    2   write ports; a higher index has higher priority
//  BYPASS    1   1 = a read returns the same-cycle write data
//  ZERO_REG  0   1 = R0 reads 0, ignores writes, never pending
// PORTS
//  clk        in   1               clock, rising edge
//  reset      in   1               asynchronous, active-low reset
//  wr_en      in   NUM_WR          per-port write enable
//  wr_addr    in   NUM_WR*ADDR_W   write addresses, port k at [k*ADDR_W +: ADDR_W]
//  wr_data    in   NUM_WR*DATA_W   write data, port k at [k*DATA_W +: DATA_W]
//  rd_addr    in   NUM_RD*ADDR_W   read addresses
//  rd_data    out  NUM_RD*DATA_W   read data (combinational)
//  rd_pend    out  NUM_RD          1 = addressed register has an outstanding producer
//  rsv_en     in   1               reserve (mark pending) rsv_addr at the next edge
//  rsv_addr   in   ADDR_W          register to reserve
//  clr_req    in   1               start bulk clear (pulse; sampled in IDLE only)
//  clr_busy   out  1               clear in progress
//  clr_done   out  1               one-cycle pulse after the last entry is cleared
// BEHAVIOUR
//  - Reset (reset=0, async): all regs=0, pending=0, FSM=IDLE, clr_busy=0, clr_done=0.
//  - Write: at posedge, for each k with wr_en[k], reg[wr_addr_k] <= wr_data_k. Same-address
//    collision: highest-index port wins. Write latency is 1 cycle.
//  - Read: pure combinational. If BYPASS and any wr_en[k] matches rd_addr_i, return the
//    winning port's wr_data; otherwise return the array. ZERO_REG and addr 0: data 0, pend 0.
//  - Scoreboard: rsv_en sets pending[rsv_addr] at the edge; any write clears pending[wr_addr].
//    If reserve and write hit the same address in one cycle, the reserve wins (pending=1).
//    rd_pend_i = pending[rd_addr_i] & ~bypass_hit_i (a bypassed value is already available).
//  - Clear FSM: IDLE -> CLEAR on clr_req. Counter cnt runs 0..DEPTH-1, one entry per cycle:
//    reg[cnt]<=0, pending[cnt]<=0. At cnt=DEPTH-1: -> DONE (clr_done=1 for 1 cycle) -> IDLE.
//    clr_busy=1 in CLEAR only. Total latency: DEPTH+1 cycles from clr_req to clr_done.
//  - During CLEAR: wr_en, rsv_en and clr_req are ignored; bypass is disabled; reads return
//    the partially-cleared array contents.
//  - Async reset mid-clear aborts the clear immediately: full reset state, no clr_done.
//  - All address arithmetic is modulo DEPTH; cnt is ADDR_W bits wide and terminates by compare.
// STRUCTURE
//  - rf_defs.vh (shared): FSM state encodings RF_IDLE=2'd0, RF_CLEAR=2'd1, RF_DONE=2'd2;
//    common DATA_W/ADDR_W defaults so the decode and hazard units agree.
//  - Sub-module rf_clear_fsm: state, cnt, clr_busy, clr_done; exports clr_we and clr_idx.
//  - Top level: storage array, write-priority mux, bypass compare per read port, pending bits.
// TESTING
//  1 Reset, then write R3=0x1234 via port 0; next cycle read R3 -> 0x1234, rd_pend=0.
//  2 Same cycle: wr port0 R5=0xAAAA and port1 R5=0x5555, read R5 -> 0x5555 (bypass);
//    next cycle the array holds 0x5555.
//  3 rsv R2 -> rd_pend=1 for R2; write R2=0x00FF -> pend=0 in the write cycle (bypass) and
//    after it; reserve+write R2 together -> pend=1.
//  4 ZERO_REG=1: write R0=0xFFFF -> read R0=0x0000, rd_pend=0 even after rsv R0.
//  5 Fill all 8 regs, clr_req -> clr_busy high 8 cycles, clr_done at cycle 9, all regs 0;
//    a write issued mid-clear is dropped.
//  6 Assert reset low at clear cnt=4 -> outputs drop immediately to reset values, no clr_done.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared definitions for the decode-stage register file.
// Widths and port counts live here so that the decode and hazard units agree on them.
// Also defines the state encoding of the bulk-clear engine.
package regfile_mp_sb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StDone  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bundles the register-file bus: write ports, read ports, reserve port and clear handshake.
// master: decode-side driver (write/read addresses, reserve, clr_req).
// slave : the register file (returns rd_data/rd_pend, clr_busy/clr_done).
// Port k of a packed field occupies [k*W +: W].
interface regfile_mp_sb_if;
    import regfile_mp_sb_pkg::*;

    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr, clr_req,
        input  rd_data, rd_pend, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr, clr_req,
        output rd_data, rd_pend, clr_busy, clr_done
    );

endinterface

// File: rtl/regfile_mp_sb_clear_fsm.sv
// Sequential bulk-clear engine: IDLE -> CLEAR (one entry per cycle) -> DONE -> IDLE.
// Ports: clk_i, rst_ni (async active-low), clr_req_i (sampled in IDLE only),
//        clr_busy_o (high in CLEAR), clr_done_o (one-cycle pulse in DONE),
//        clr_we_o / clr_idx_o (entry to zero at the next edge).
module regfile_mp_sb_clear_fsm
    import regfile_mp_sb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_idx_o
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_busy_o = 1'b0;
        clr_done_o = 1'b0;
        clr_we_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                clr_busy_o = 1'b1;
                clr_we_o   = 1'b1;
                // Terminate by compare; the counter never wraps.
                if (cnt_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                clr_done_o = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign clr_idx_o = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write->read bypass, optional hardwired-zero R0,
// per-register pending scoreboard and a sequential bulk-clear engine.
// Ports: clk_i, rst_ni (async active-low), bus (regfile_mp_sb_if.slave).
// Parameters: BYPASS (same-cycle write data visible on reads), ZERO_REG (R0 reads 0).
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input logic              clk_i,
    input logic              rst_ni,
    regfile_mp_sb_if.slave   bus
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;

    regfile_mp_sb_clear_fsm u_clear_fsm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_req_i  (bus.clr_req),
        .clr_busy_o (bus.clr_busy),
        .clr_done_o (bus.clr_done),
        .clr_we_o   (clr_we),
        .clr_idx_o  (clr_idx)
    );

    // Next state: the clear engine owns the array while active; otherwise writes in ascending
    // port order so the highest port wins, then reserve overrides the write's pending clear.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (clr_we) begin
            regs_d[clr_idx] = '0;
            pend_d[clr_idx] = 1'b0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wr_en[k]) begin
                    regs_d[bus.wr_addr[k*ADDR_W +: ADDR_W]] = bus.wr_data[k*DATA_W +: DATA_W];
                    pend_d[bus.wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (bus.rsv_en) begin
                pend_d[bus.rsv_addr] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            regs_d[0] = '0;
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              hit;
        logic              pend;

        assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            hit  = 1'b0;
            data = regs_q[ra];
            // Bypass is off during a clear since the writes themselves are dropped.
            if (BYPASS && !clr_we) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.wr_en[k] && (bus.wr_addr[k*ADDR_W +: ADDR_W] == ra)) begin
                        hit  = 1'b1;
                        data = bus.wr_data[k*DATA_W +: DATA_W];
                    end
                end
            end
            // A bypassed value is already available, so it is not a hazard.
            pend = pend_q[ra] & ~hit;
            if (ZERO_REG && (ra == '0)) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = data;
        assign bus.rd_pend[i]                  = pend;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (BYPASS=1, ZERO_REG=1): table-driven read/write/
// reserve vectors checked through an expected-result queue, then hand-written sequences
// for the bulk clear, a write dropped mid-clear, and reset aborting a clear.
module tb_regfile_mp_sb;
    import regfile_mp_sb_pkg::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_sb_if bus ();

    regfile_mp_sb #(
        .BYPASS   (1'b1),
        .ZERO_REG (1'b1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic [1:0]  we;
        logic [2:0]  wa0;
        logic [15:0] wd0;
        logic [2:0]  wa1;
        logic [15:0] wd1;
        logic        rsv;
        logic [2:0]  rsva;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic [15:0] ed0;
        logic        ep0;
        logic [15:0] ed1;
        logic        ep1;
    } vec_t;

    typedef struct {
        logic [15:0] d0;
        logic        p0;
        logic [15:0] d1;
        logic        p1;
    } exp_t;

    localparam int NVec = 17;
    vec_t vecs [NVec];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [2:0] wa0, input logic [15:0] wd0,
                         input logic [2:0] wa1, input logic [15:0] wd1, input logic rsv,
                         input logic [2:0] rsva, input logic [2:0] ra0, input logic [2:0] ra1);
        bus.wr_en    = we;
        bus.wr_addr  = {wa1, wa0};
        bus.wr_data  = {wd1, wd0};
        bus.rsv_en   = rsv;
        bus.rsv_addr = rsva;
        bus.rd_addr  = {ra1, ra0};
    endtask

    initial begin
        exp_t e;

        //            we     wa0   wd0       wa1   wd1       rsv   rsva  ra0   ra1
        //            ed0       ep0   ed1       ep1
        vecs[0]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd0,
                     16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{2'b01, 3'd3, 16'h1234, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd5,
                     16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd1,
                     16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{2'b11, 3'd5, 16'hAAAA, 3'd5, 16'h5555, 1'b0, 3'd0, 3'd5, 3'd3,
                     16'h5555, 1'b0, 16'h1234, 1'b0};
        vecs[4]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd2,
                     16'h5555, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd5,
                     16'h0000, 1'b0, 16'h5555, 1'b0};
        vecs[6]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd0,
                     16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[7]  = '{2'b01, 3'd2, 16'h00FF, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd2,
                     16'h00FF, 1'b0, 16'h00FF, 1'b0};
        vecs[8]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd7,
                     16'h00FF, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{2'b10, 3'd0, 16'h0000, 3'd2, 16'h0F0F, 1'b1, 3'd2, 3'd2, 3'd3,
                     16'h0F0F, 1'b0, 16'h1234, 1'b0};
        vecs[10] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd5,
                     16'h0F0F, 1'b1, 16'h5555, 1'b0};
        vecs[11] = '{2'b01, 3'd0, 16'hFFFF, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 3'd2,
                     16'h0000, 1'b0, 16'h0F0F, 1'b1};
        vecs[12] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd1,
                     16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[13] = '{2'b11, 3'd7, 16'hBEEF, 3'd6, 16'hCAFE, 1'b0, 3'd0, 3'd7, 3'd6,
                     16'hBEEF, 1'b0, 16'hCAFE, 1'b0};
        vecs[14] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd7,
                     16'hCAFE, 1'b0, 16'hBEEF, 1'b0};
        vecs[15] = '{2'b01, 3'd2, 16'h0001, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd4,
                     16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[16] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd6,
                     16'h0001, 1'b0, 16'hCAFE, 1'b0};

        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        bus.clr_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset clr_busy", 32'(bus.clr_busy), 32'd0);
        chk("reset clr_done", 32'(bus.clr_done), 32'd0);
        rst_ni = 1'b1;

        // Table: expected reads queued as each vector is driven, compared once settled.
        for (int i = 0; i < NVec; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                  vecs[i].rsv, vecs[i].rsva, vecs[i].ra0, vecs[i].ra1);
            sb_q.push_back('{vecs[i].ed0, vecs[i].ep0, vecs[i].ed1, vecs[i].ep1});
            #1;
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d scoreboard empty", i), 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d rd_data0", i), 32'(bus.rd_data[15:0]), 32'(e.d0));
                chk($sformatf("v%0d rd_pend0", i), 32'(bus.rd_pend[0]), 32'(e.p0));
                chk($sformatf("v%0d rd_data1", i), 32'(bus.rd_data[31:16]), 32'(e.d1));
                chk($sformatf("v%0d rd_pend1", i), 32'(bus.rd_pend[1]), 32'(e.p1));
            end
        end

        // Bulk clear: fill R1..R7, reserve R4, then clear.
        for (int a = 1; a < 8; a += 2) begin
            @(negedge clk);
            drive((a == 7) ? 2'b01 : 2'b11, 3'(a), 16'h1000 + 16'(a),
                  3'(a + 1), 16'h1000 + 16'(a + 1), (a == 7), 3'd4, 3'd0, 3'd0);
        end
        @(negedge clk);
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd4, 3'd6);
        bus.clr_req = 1'b1;
        #1;
        chk("pre-clear R4 pend", 32'(bus.rd_pend[0]), 32'd1);
        chk("pre-clear R6 data", 32'(bus.rd_data[31:16]), 32'h1006);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.clr_req = 1'b0;
            if (c == 4) begin
                drive(2'b01, 3'd1, 16'hDEAD, 3'd0, 16'h0, 1'b1, 3'd1, 3'd1, 3'd6);
            end else begin
                drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1, 3'd6);
            end
            #1;
            chk($sformatf("clear c%0d clr_busy", c), 32'(bus.clr_busy), 32'(c <= 8));
            chk($sformatf("clear c%0d clr_done", c), 32'(bus.clr_done), 32'(c == 9));
            if (c == 4) begin
                chk("mid-clear R1 no bypass", 32'(bus.rd_data[15:0]), 32'h0000);
                chk("mid-clear R6 not yet cleared", 32'(bus.rd_data[31:16]), 32'h1006);
            end
        end
        for (int a = 0; a < 8; a += 2) begin
            @(negedge clk);
            drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0, 3'(a), 3'(a + 1));
            #1;
            chk($sformatf("post-clear R%0d data", a), 32'(bus.rd_data[15:0]), 32'd0);
            chk($sformatf("post-clear R%0d pend", a), 32'(bus.rd_pend[0]), 32'd0);
            chk($sformatf("post-clear R%0d data", a + 1), 32'(bus.rd_data[31:16]), 32'd0);
            chk($sformatf("post-clear R%0d pend", a + 1), 32'(bus.rd_pend[1]), 32'd0);
        end

        // Reset aborts a clear at cnt=4.
        @(negedge clk);
        drive(2'b01, 3'd7, 16'h7777, 3'd0, 16'h0, 1'b0, 3'd0, 3'd7, 3'd0);
        @(negedge clk);
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd7, 3'd0);
        bus.clr_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.clr_req = 1'b0;
        end
        #1;
        chk("abort pre clr_busy", 32'(bus.clr_busy), 32'd1);
        chk("abort pre R7 data", 32'(bus.rd_data[15:0]), 32'h7777);
        rst_ni = 1'b0;
        #1;
        chk("abort clr_busy", 32'(bus.clr_busy), 32'd0);
        chk("abort clr_done", 32'(bus.clr_done), 32'd0);
        chk("abort R7 data", 32'(bus.rd_data[15:0]), 32'h0000);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("after abort c%0d clr_done", c), 32'(bus.clr_done), 32'd0);
            chk($sformatf("after abort c%0d clr_busy", c), 32'(bus.clr_busy), 32'd0);
        end
        @(negedge clk);
        drive(2'b10, 3'd0, 16'h0, 3'd7, 16'h4242, 1'b0, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd7, 3'd0);
        #1;
        chk("recovered write R7", 32'(bus.rd_data[15:0]), 32'h4242);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
